ps2_scancode_rx: RTL and testbench

PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

---
 rtl/ps2_scancode_rx_if.sv | 22 ++
 rtl/ps2_scancode_rx.sv | 178 +++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scancode_rx_if.sv
// Key event bus from the PS/2 scancode receiver to the scancode-to-opcode decoder.
// The receiver drives it through the master modport; consumers read it through slave.
interface ps2_scancode_rx_if;
  logic [7:0] keyboardValue;
  logic       key_valid;
  logic       key_extended;
  logic       frame_error;

  modport master (
    output keyboardValue,
    output key_valid,
    output key_extended,
    output frame_error
  );

  modport slave (
    input keyboardValue,
    input key_valid,
    input key_extended,
    input frame_error
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches ps2_clk, deframes 11-bit frames,
// and turns E0/F0 prefixed scancodes into make-code events with an extended flag.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ps2_clk,
  input  logic                      ps2_data,
  ps2_scancode_rx_if.master         key_if
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e         state_q, state_d;
  logic           clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
  logic           data_meta_q, data_meta_d, data_sync_q, data_sync_d;
  logic           filt_clk_q, filt_clk_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic           brk_q, brk_d;
  logic           ext_q, ext_d;
  logic [7:0]     key_value_q, key_value_d;
  logic           key_valid_q, key_valid_d;
  logic           key_ext_q, key_ext_d;
  logic           frame_err_q, frame_err_d;
  logic           fall;

  // NOTE: every signal gets its default before any branch so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    clk_meta_d  = ps2_clk;
    clk_sync_d  = clk_meta_q;
    data_meta_d = ps2_data;
    data_sync_d = data_meta_q;
    filt_clk_d  = filt_clk_q;
    filt_cnt_d  = filt_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    brk_d       = brk_q;
    ext_d       = ext_q;
    key_value_d = key_value_q;
    key_ext_d   = key_ext_q;
    key_valid_d = 1'b0;
    frame_err_d = 1'b0;
    fall        = 1'b0;

    // The filtered level flips only once FILTER_LEN consecutive samples disagree with it.
    if (clk_sync_q == filt_clk_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
      filt_clk_d = clk_sync_q;
      filt_cnt_d = '0;
      fall       = filt_clk_q;
    end else begin
      filt_cnt_d = filt_cnt_q + FCW'(1);
    end

    if (fall || state_q == IDLE) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TCW'(1);
    end

    case (state_q)
      IDLE: begin
        if (fall && !data_sync_q) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = data_sync_q;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (data_sync_q && (^{shift_q, parity_q})) begin
            if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (brk_q) begin
              // Break code: the release of this key is swallowed along with any E0 prefix.
              brk_d = 1'b0;
              ext_d = 1'b0;
            end else begin
              key_value_d = shift_q;
              key_ext_d   = ext_q;
              key_valid_d = 1'b1;
              ext_d       = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled keyboard abandons the partial frame; prefix flags are kept.
    if (state_q != IDLE && !fall && tmo_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
      state_d     = IDLE;
      tmo_cnt_d   = '0;
      frame_err_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b0;
      data_sync_q <= 1'b0;
      filt_clk_q  <= 1'b1;
      filt_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      key_value_q <= 8'h00;
      key_valid_q <= 1'b0;
      key_ext_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
      filt_clk_q  <= filt_clk_d;
      filt_cnt_q  <= filt_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      key_value_q <= key_value_d;
      key_valid_q <= key_valid_d;
      key_ext_q   <= key_ext_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign key_if.keyboardValue = key_value_q;
  assign key_if.key_valid     = key_valid_q;
  assign key_if.key_extended  = key_ext_q;
  assign key_if.frame_error   = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: drives PS/2 frames bit by bit and checks
// key events, prefix handling, error pulses, glitch rejection, timeout and reset abort.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 200;

  logic clk;
  logic reset_n;
  logic ps2_clk;
  logic ps2_data;

  ps2_scancode_rx_if kif ();

  ps2_scancode_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_if   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int kv_cnt  = 0;
  int fe_cnt  = 0;
  int kv_wide = 0;
  int fe_wide = 0;
  int exp_kv  = 0;
  int exp_fe  = 0;
  int lat     = -1;
  logic kv_prev = 1'b0;
  logic fe_prev = 1'b0;

  // Pulse monitor: counts pulses and any pulse lasting more than one cycle.
  always @(negedge clk) begin
    if (kif.key_valid) kv_cnt++;
    if (kif.frame_error) fe_cnt++;
    if (kif.key_valid && kv_prev) kv_wide++;
    if (kif.frame_error && fe_prev) fe_wide++;
    kv_prev = kif.key_valid;
    fe_prev = kif.frame_error;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data setup, 20-cycle low half, 10-cycle high half.
  // glitch > 0 inserts a short high pulse in the low half and a short low pulse in the high half.
  task automatic ps2_bit(input logic b, input int glitch);
    ps2_data = b;
    wait_neg(10);
    ps2_clk = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (kif.key_valid && lat < 0) lat = i;
      if (glitch > 0 && i == 10) ps2_clk = 1'b1;
      if (glitch > 0 && i == 10 + glitch) ps2_clk = 1'b0;
    end
    ps2_clk = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (glitch > 0 && i == 3) ps2_clk = 1'b0;
      if (glitch > 0 && i == 3 + glitch) ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                            input int glitch);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit((~^b) ^ bad_par, 0);
    lat = -1;
    ps2_bit(stop, 0);
    ps2_data = 1'b1;
    wait_neg(20);
  endtask

  initial begin
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_neg(5);
    check("rst_value", {24'h0, kif.keyboardValue}, 32'h00);
    check("rst_valid", {31'h0, kif.key_valid}, 32'h0);
    check("rst_ext",   {31'h0, kif.key_extended}, 32'h0);
    check("rst_ferr",  {31'h0, kif.frame_error}, 32'h0);
    reset_n = 1'b1;
    wait_neg(20);

    // Plain make code, with exact latency from the stop-bit ps2_clk fall.
    send_frame(8'h1C, 1'b0, 1'b1, 0);
    exp_kv++;
    check("1c_latency", lat, 6);
    check("1c_kv_cnt", kv_cnt, exp_kv);
    check("1c_value", {24'h0, kif.keyboardValue}, 32'h1C);
    check("1c_ext", {31'h0, kif.key_extended}, 32'h0);

    // Release suppressed, then typematic repeat of the same make code.
    send_frame(8'hF0, 1'b0, 1'b1, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 0);
    check("brk_kv_cnt", kv_cnt, exp_kv);
    check("brk_value", {24'h0, kif.keyboardValue}, 32'h1C);
    send_frame(8'hF0, 1'b0, 1'b1, 0);
    send_frame(8'h29, 1'b0, 1'b1, 0);
    check("brk29_kv_cnt", kv_cnt, exp_kv);
    check("brk29_value", {24'h0, kif.keyboardValue}, 32'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 0);
    exp_kv++;
    check("rep_kv_cnt", kv_cnt, exp_kv);
    check("rep_latency", lat, 6);
    check("rep_value", {24'h0, kif.keyboardValue}, 32'h1C);

    // Extended prefix applies to exactly one make code.
    send_frame(8'hE0, 1'b0, 1'b1, 0);
    send_frame(8'h14, 1'b0, 1'b1, 0);
    exp_kv++;
    check("e0_value", {24'h0, kif.keyboardValue}, 32'h14);
    check("e0_ext", {31'h0, kif.key_extended}, 32'h1);
    send_frame(8'h29, 1'b0, 1'b1, 0);
    exp_kv++;
    check("29_value", {24'h0, kif.keyboardValue}, 32'h29);
    check("29_ext", {31'h0, kif.key_extended}, 32'h0);
    check("e0_kv_cnt", kv_cnt, exp_kv);

    // Parity and stop-bit errors.
    send_frame(8'h29, 1'b1, 1'b1, 0);
    exp_fe++;
    check("par_fe_cnt", fe_cnt, exp_fe);
    check("par_kv_cnt", kv_cnt, exp_kv);
    check("par_value", {24'h0, kif.keyboardValue}, 32'h29);
    send_frame(8'h33, 1'b0, 1'b0, 0);
    exp_fe++;
    check("stop_fe_cnt", fe_cnt, exp_fe);
    check("stop_kv_cnt", kv_cnt, exp_kv);

    // A frame error between E0 and the make code keeps the extended flag.
    send_frame(8'hE0, 1'b0, 1'b1, 0);
    send_frame(8'h55, 1'b1, 1'b1, 0);
    exp_fe++;
    send_frame(8'h14, 1'b0, 1'b1, 0);
    exp_kv++;
    check("keep_fe_cnt", fe_cnt, exp_fe);
    check("keep_value", {24'h0, kif.keyboardValue}, 32'h14);
    check("keep_ext", {31'h0, kif.key_extended}, 32'h1);

    // Timeout: start bit plus four data bits, then ps2_clk stays idle.
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 0);
    ps2_data = 1'b1;
    wait_neg(TIMEOUT_CYCLES + 100);
    exp_fe++;
    check("tmo_fe_cnt", fe_cnt, exp_fe);
    check("tmo_kv_cnt", kv_cnt, exp_kv);
    send_frame(8'h16, 1'b0, 1'b1, 0);
    exp_kv++;
    check("tmo_next_value", {24'h0, kif.keyboardValue}, 32'h16);
    check("tmo_next_ext", {31'h0, kif.key_extended}, 32'h0);
    check("tmo_next_kv_cnt", kv_cnt, exp_kv);

    // Short ps2_clk glitches must not add bits.
    send_frame(8'h5A, 1'b0, 1'b1, 1);
    exp_kv++;
    check("glitch1_value", {24'h0, kif.keyboardValue}, 32'h5A);
    send_frame(8'hA5, 1'b0, 1'b1, FILTER_LEN - 1);
    exp_kv++;
    check("glitch3_value", {24'h0, kif.keyboardValue}, 32'hA5);
    check("glitch_kv_cnt", kv_cnt, exp_kv);
    check("glitch_fe_cnt", fe_cnt, exp_fe);

    // A clock pulse with data high in IDLE is not a start bit.
    ps2_bit(1'b1, 0);
    wait_neg(TIMEOUT_CYCLES + 50);
    check("idle_fe_cnt", fe_cnt, exp_fe);
    send_frame(8'h66, 1'b0, 1'b1, 0);
    exp_kv++;
    check("idle_next_value", {24'h0, kif.keyboardValue}, 32'h66);

    // Reset mid-frame after an E0 prefix: silent abort, flags cleared.
    send_frame(8'hE0, 1'b0, 1'b1, 0);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0, 0);
    reset_n = 1'b0;
    wait_neg(5);
    check("midrst_value", {24'h0, kif.keyboardValue}, 32'h00);
    reset_n = 1'b1;
    ps2_data = 1'b1;
    wait_neg(TIMEOUT_CYCLES + 100);
    check("midrst_fe_cnt", fe_cnt, exp_fe);
    check("midrst_kv_cnt", kv_cnt, exp_kv);
    send_frame(8'h1C, 1'b0, 1'b1, 0);
    exp_kv++;
    check("postrst_value", {24'h0, kif.keyboardValue}, 32'h1C);
    check("postrst_ext", {31'h0, kif.key_extended}, 32'h0);
    check("postrst_kv_cnt", kv_cnt, exp_kv);

    check("kv_single_cycle", kv_wide, 0);
    check("fe_single_cycle", fe_wide, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
